// File: rtl/teclado_cmd_parser.sv
// teclado_cmd_parser
//   Turns the ASCII byte stream from the Bluetooth UART receiver into painter
//   commands. A line is a 2-letter mnemonic, optionally followed by ",X,Y",
//   and ends with LF. CR is ignored everywhere. Malformed lines are dropped.
//   A line left half-finished for TIMEOUT_CYC idle cycles is also dropped.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   rx_data, rx_valid   byte from the UART receiver and its one-cycle strobe
//   cmd_valid           one-cycle pulse, the cycle after the terminating LF
//   cmd_id, x, y        command code and coordinates, held until the next pulse
//   err_valid, err_code only with TECLADO_CMD_PARSER_ERR_EN defined:
//                       1 = syntax/mnemonic, 2 = range/digit count, 3 = timeout
//
// Build option: `define TECLADO_CMD_PARSER_ERR_EN adds the error report ports.

module teclado_cmd_parser #(
  parameter int COORD_W     = 7,
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               cmd_valid,
  output logic [3:0]         cmd_id,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
`ifdef TECLADO_CMD_PARSER_ERR_EN
  ,
  output logic               err_valid,
  output logic [1:0]         err_code
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [DW-1:0] DIG_MAX   = DW'(MAX_DIGITS);
  localparam logic [13:0]   COORD_MAX = 14'((1 << COORD_W) - 1);

  typedef enum logic [2:0] {IDLE, M1, M2, XD, YD, DISCARD} state_t;

  state_t               state;
  logic [7:0]           c1;       // first mnemonic char, already upper-cased
  logic [3:0]           code;     // looked-up command code for this line
  logic [9:0]           acc;      // decimal accumulator for the current field
  logic [DW-1:0]        ndig;     // digits seen in the current field
  logic [COORD_W-1:0]   x_acc;    // finished X field
  logic [TW-1:0]        tmo_cnt;

  // Byte classification
  logic [7:0]  up_c;
  logic        is_letter, is_digit, is_lf, is_cr, is_comma;
  logic [3:0]  mnem;
  logic [13:0] acc_nxt;
  logic        dig_err;
  logic        fault_syn, fault_rng, fault;

  function automatic logic [3:0] mnem_lookup(input logic [15:0] p);
    case (p)
      16'h5550: return 4'd1;  // UP
      16'h444E: return 4'd2;  // DN
      16'h4C46: return 4'd3;  // LF
      16'h5254: return 4'd4;  // RT
      16'h5054: return 4'd5;  // PT
      16'h4552: return 4'd6;  // ER
      16'h434C: return 4'd7;  // CL
      16'h434F: return 4'd8;  // CO
      default:  return 4'd0;  // 0 marks an unknown pair
    endcase
  endfunction

  // Clearing bit 5 folds a-z onto A-Z; no other byte lands in 'A'..'Z'.
  assign up_c      = rx_data & 8'hDF;
  assign is_letter = (up_c >= 8'h41) && (up_c <= 8'h5A);
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_lf     = (rx_data == 8'h0A);
  assign is_cr     = (rx_data == 8'h0D);
  assign is_comma  = (rx_data == 8'h2C);
  assign mnem      = mnem_lookup({c1, up_c});

  // acc never holds more than COORD_MAX, so 14 bits cannot overflow here.
  assign acc_nxt = ({4'd0, acc} * 14'd10) + {10'd0, rx_data[3:0]};
  assign dig_err = (ndig == DIG_MAX) || (acc_nxt > COORD_MAX);

  // Does the current byte break the line? Range/digit faults outrank syntax.
  always_comb begin
    fault_syn = 1'b0;
    fault_rng = 1'b0;
    if (rx_valid && !is_cr) begin
      case (state)
        IDLE: fault_syn = !is_lf && !is_letter;
        M1:   fault_syn = !is_letter || (mnem == 4'd0);
        M2:   fault_syn = !is_lf && !is_comma;
        XD:   if (is_digit) fault_rng = dig_err;
              else          fault_syn = !(is_comma && (ndig != '0));
        YD:   if (is_digit) fault_rng = dig_err;
              else          fault_syn = !(is_lf && (ndig != '0));
        default: ;
      endcase
    end
  end
  assign fault = fault_syn | fault_rng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c1        <= '0;
      code      <= '0;
      acc       <= '0;
      ndig      <= '0;
      x_acc     <= '0;
      tmo_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      x         <= '0;
      y         <= '0;
`ifdef TECLADO_CMD_PARSER_ERR_EN
      err_valid <= 1'b0;
      err_code  <= '0;
`endif
    end else begin
      cmd_valid <= 1'b0;
`ifdef TECLADO_CMD_PARSER_ERR_EN
      err_valid <= 1'b0;
`endif
      if (rx_valid) begin
        // A byte always beats an expiring timeout.
        tmo_cnt <= '0;
        if (fault) begin
          // When the offending byte is itself the LF, the line is already
          // over, so skip DISCARD rather than swallow the next line.
          state <= is_lf ? IDLE : DISCARD;
`ifdef TECLADO_CMD_PARSER_ERR_EN
          err_valid <= 1'b1;
          err_code  <= fault_rng ? 2'd2 : 2'd1;
`endif
        end else if (!is_cr) begin
          case (state)
            IDLE: if (is_letter) begin
              c1    <= up_c;
              state <= M1;
            end
            M1: begin
              code  <= mnem;
              state <= M2;
            end
            M2: if (is_lf) begin
              cmd_valid <= 1'b1;
              cmd_id    <= code;
              x         <= '0;
              y         <= '0;
              state     <= IDLE;
            end else begin
              acc   <= '0;
              ndig  <= '0;
              state <= XD;
            end
            XD: if (is_digit) begin
              acc  <= acc_nxt[9:0];
              ndig <= ndig + DW'(1);
            end else begin
              x_acc <= acc[COORD_W-1:0];
              acc   <= '0;
              ndig  <= '0;
              state <= YD;
            end
            YD: if (is_digit) begin
              acc  <= acc_nxt[9:0];
              ndig <= ndig + DW'(1);
            end else begin
              cmd_valid <= 1'b1;
              cmd_id    <= code;
              x         <= x_acc;
              y         <= acc[COORD_W-1:0];
              state     <= IDLE;
            end
            DISCARD: if (is_lf) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_MAX) begin
        state <= IDLE;
`ifdef TECLADO_CMD_PARSER_ERR_EN
        err_valid <= 1'b1;
        err_code  <= 2'd3;
`endif
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_teclado_cmd_parser.sv
module tb_teclado_cmd_parser;

  localparam int CW  = 7;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          cmd_valid;
  logic [3:0]    cmd_id;
  logic [CW-1:0] x, y;
`ifdef TECLADO_CMD_PARSER_ERR_EN
  logic          err_valid;
  logic [1:0]    err_code;
`endif

  teclado_cmd_parser #(.COORD_W(CW), .MAX_DIGITS(3), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .x(x), .y(y)
`ifdef TECLADO_CMD_PARSER_ERR_EN
    , .err_valid(err_valid), .err_code(err_code)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int id; int xx; int yy; } pulse_t;
  typedef struct { string line; int np; int id; int xx; int yy; int ec; } vec_t;

  pulse_t pq[$];
  int     eq[$];
  int     checks = 0;
  int     errors = 0;
  int     last_id = 0, last_x = 0, last_y = 0;

  always @(negedge clk) begin
    if (cmd_valid) pq.push_back('{int'(cmd_id), int'(x), int'(y)});
`ifdef TECLADO_CMD_PARSER_ERR_EN
    if (err_valid) eq.push_back(int'(err_code));
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one byte per cycle back-to-back; returns 1 time unit after the
  // edge that consumed the last byte, with rx_valid low.
  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data  = s[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_pulse(input string name, input int id, input int xx, input int yy);
    chk({name, "_count"}, pq.size(), 1);
    if (pq.size() == 1) begin
      chk({name, "_id"}, pq[0].id, id);
      chk({name, "_x"},  pq[0].xx, xx);
      chk({name, "_y"},  pq[0].yy, yy);
    end
  endtask

  task automatic chk_err(input string name, input int ec);
`ifdef TECLADO_CMD_PARSER_ERR_EN
    chk({name, "_errs"}, eq.size(), (ec != 0) ? 1 : 0);
    if (ec != 0 && eq.size() == 1) chk({name, "_ecode"}, eq[0], ec);
`endif
  endtask

  vec_t vt[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"UP,12,4\n",    1, 1, 12, 4,   0};
    vt[1]  = '{"PT,128,3\n",   0, 0, 0, 0,    2};
    vt[2]  = '{"PT,0007,1\n",  0, 0, 0, 0,    2};
    vt[3]  = '{"PT,,1\n",      0, 0, 0, 0,    1};
    vt[4]  = '{"XX,1,1\n",     0, 0, 0, 0,    1};
    vt[5]  = '{"ER,127,127\n", 1, 6, 127, 127, 0};
    vt[6]  = '{"\n",           0, 0, 0, 0,    0};
    vt[7]  = '{"dn,0,99\n",    1, 2, 0, 99,   0};
    vt[8]  = '{"Lf\r,1,2\r\n", 1, 3, 1, 2,    0};
    vt[9]  = '{"RT\n",         1, 4, 0, 0,    0};
    vt[10] = '{"UP,3,\n\n",    0, 0, 0, 0,    1};
    vt[11] = '{"PT,1,2,3\n",   0, 0, 0, 0,    1};
    vt[12] = '{"1,2\n",        0, 0, 0, 0,    1};
    vt[13] = '{"PT,99,100\n",  1, 5, 99, 100, 0};

    // Reset state
    idle(2);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    rst_n = 1'b1;
    idle(2);

    // Exact latency: pulse in the cycle right after the LF strobe, one cycle wide
    pq.delete(); eq.delete();
    send_line("UP,12,4\n");
    chk("lat_valid", int'(cmd_valid), 1);
    chk("lat_id", int'(cmd_id), 1);
    chk("lat_x", int'(x), 12);
    chk("lat_y", int'(y), 4);
    idle(1);
    chk("lat_valid_drop", int'(cmd_valid), 0);
    idle(2);
    last_id = 1; last_x = 12; last_y = 4;

    // Table-driven lines
    for (int i = 0; i < 14; i++) begin
      pq.delete(); eq.delete();
      send_line(vt[i].line);
      idle(3);
      if (vt[i].np == 1) begin
        chk_pulse($sformatf("vec%0d", i), vt[i].id, vt[i].xx, vt[i].yy);
        last_id = vt[i].id; last_x = vt[i].xx; last_y = vt[i].yy;
      end else begin
        chk($sformatf("vec%0d_count", i), pq.size(), 0);
      end
      chk($sformatf("vec%0d_hold_id", i), int'(cmd_id), last_id);
      chk($sformatf("vec%0d_hold_x", i),  int'(x), last_x);
      chk($sformatf("vec%0d_hold_y", i),  int'(y), last_y);
      chk_err($sformatf("vec%0d", i), vt[i].ec);
    end

    // Back-to-back lines; 'C' strobes in the cycle cmd_valid is high
    pq.delete(); eq.delete();
    send_line("cl\r\nCO,5,0\n");
    idle(3);
    chk("b2b_count", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("b2b0_id", pq[0].id, 7); chk("b2b0_x", pq[0].xx, 0); chk("b2b0_y", pq[0].yy, 0);
      chk("b2b1_id", pq[1].id, 8); chk("b2b1_x", pq[1].xx, 5); chk("b2b1_y", pq[1].yy, 0);
    end
    chk_err("b2b", 0);

    // Long silence mid-line: partial line dropped, next line parses
    pq.delete(); eq.delete();
    send_line("DN,3");
    idle(TMO + 3);
    send_line("RT,1,2\n");
    idle(3);
    chk_pulse("tmo", 4, 1, 2);
    chk_err("tmo", 3);

    // Byte in the expiry cycle wins
    pq.delete(); eq.delete();
    send_line("DN,3");
    idle(TMO);
    send_line(",4\n");
    idle(3);
    chk_pulse("tmo_edge", 2, 3, 4);
    chk_err("tmo_edge", 0);

    // One cycle later the line has already expired
    pq.delete(); eq.delete();
    send_line("DN,3");
    idle(TMO + 1);
    send_line(",4\n");
    idle(3);
    chk("tmo_late_count", pq.size(), 0);
`ifdef TECLADO_CMD_PARSER_ERR_EN
    chk("tmo_late_errs", eq.size(), 2);
    if (eq.size() == 2) begin
      chk("tmo_late_e0", eq[0], 3);
      chk("tmo_late_e1", eq[1], 1);
    end
`endif

    // Reset mid-line
    pq.delete(); eq.delete();
    send_line("UP,1");
    rst_n = 1'b0;
    idle(3);
    chk("mrst_id", int'(cmd_id), 0);
    chk("mrst_x", int'(x), 0);
    chk("mrst_y", int'(y), 0);
    rst_n = 1'b1;
    idle(1);
    send_line(",2\n");
    idle(3);
    chk("mrst_count", pq.size(), 0);
    chk("mrst_hold_id", int'(cmd_id), 0);
    chk("mrst_hold_x", int'(x), 0);
    chk("mrst_hold_y", int'(y), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/teclado_cmd_parser.md
Name: teclado_cmd_parser

Overview:
- Parses the ASCII command stream from the Bluetooth UART into painter commands.
- Sits directly downstream of the UART byte receiver (rx byte + strobe) and upstream of the cursor/paint controller.
- Line format: 2-letter mnemonic, optionally ",X,Y", terminated by LF (0x0A). Example: "UP,12,4\n" gives cmd_id=1, x=12, y=4.

Parameters:
- COORD_W, 7, coordinate width; legal value range 0..2^COORD_W-1.
- MAX_DIGITS, 3, maximum decimal digits per coordinate field.
- TIMEOUT_CYC, 500000, idle cycles allowed inside a partial line before the parser resets (about 10 byte times at 9600 baud, 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid when rx_valid=1.
- rx_valid  in  1  single-cycle byte strobe from the UART receiver.
- cmd_valid  out  1  single-cycle pulse; a complete legal command is present.
- cmd_id  out  4  command code, held until the next cmd_valid.
- x  out  COORD_W  X coordinate (or colour index for CO), held.
- y  out  COORD_W  Y coordinate, held.

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-low (rst_n). All outputs, accumulators, the timeout counter and the FSM clear to 0 / IDLE.
- Mnemonic table (case-insensitive; bit 5 masked before compare):
  - UP=1, DN=2, LF=3, RT=4, PT=5, ER=6, CL=7, CO=8.
  - cmd_id 0 is reserved and never emitted.
  - Any other pair is an error.
- CR (0x0D) is ignored in every state.
- Bytes are consumed only on cycles where rx_valid=1.
- FSM states: IDLE, M1, M2, XD, YD, DISCARD.
  - IDLE: LF is an empty line, ignored. Letter: store it, go to M1. Any other byte: DISCARD.
  - M1: letter: store second char, look up the mnemonic; known goes to M2, unknown goes to DISCARD. Else DISCARD.
  - M2: LF: emit with x=y=0. ',': clear the X accumulator, go to XD. Else DISCARD.
  - XD: digit: acc = acc*10 + digit. ',' with at least one digit: go to YD. Else DISCARD.
  - YD: digit: accumulate. LF with at least one digit: emit. Else DISCARD.
  - DISCARD: drop bytes until LF, then return to IDLE. No output is produced.
- Field errors (go to DISCARD):
  - more than MAX_DIGITS digits;
  - accumulated value above 2^COORD_W-1 (internal accumulator is 10 bits, range-checked at every digit);
  - empty field (",," or ",\n").
- Emit: cmd_valid is high for exactly one cycle, the cycle after the terminating LF strobe. cmd_id, x and y update on that same edge. FSM returns to IDLE.
- Timeout:
  - Counter is cleared in IDLE and on every rx_valid.
  - Otherwise it increments.
  - On reaching TIMEOUT_CYC in any non-IDLE state, the FSM goes to IDLE and the partial line is dropped.
  - A byte arriving in the expiry cycle wins: it is processed and the counter clears.
  - The DISCARD state also times out to IDLE.
- Back-to-back lines are accepted with no gap requirement. A strobe in the cycle cmd_valid is high belongs to the next line.
- Reset asserted mid-line: immediate return to IDLE; the line is lost and no cmd_valid is produced.

Optional Feature:
- Macro: TECLADO_CMD_PARSER_ERR_EN.
- When defined, adds output ports err_valid (1) and err_code (2).
  - err_valid is a single-cycle pulse on entry to DISCARD or on timeout.
  - err_code values: 1 = bad mnemonic/syntax, 2 = coordinate range/digit count, 3 = timeout.
  - Error priority within one byte: code 2 over code 1.
- When undefined, these ports do not exist and errors are silent. Core behaviour is identical in both builds.

Test Plan:
- Bytes "UP,12,4\n" at 9600 baud -> one cmd_valid pulse 1 cycle after the LF strobe; cmd_id=1, x=12, y=4.
- "cl\r\n" then "CO,5,0\n" back-to-back -> two pulses: (7,0,0) then (8,5,0); CR ignored; lowercase accepted.
- "PT,128,3\n", "PT,0007,1\n", "PT,,1\n", "XX,1,1\n" -> no cmd_valid. With ERR_EN: codes 2, 2, 1, 1. A following "ER,127,127\n" -> (6,127,127).
- "DN,3" then silence for TIMEOUT_CYC cycles, then "RT,1,2\n" -> no pulse for DN (ERR_EN: code 3); pulse (4,1,2).
- rst_n low for 3 cycles between "UP,1" and ",2\n" -> no cmd_valid; outputs read 0 after reset.
- Byte strobe in the exact cycle the timeout would expire -> byte processed, no timeout error.
